// File: rtl/rx_mac_stats_pkg.sv
// Shared definitions for the multi-channel RX MAC statistics unit.
// No logic of its own; constants, counter-set layout and the saturating adder.
// No flow control.
package rx_mac_stats_pkg;

  // Per-channel MI window offsets (channel c lives at c*0x40)
  localparam logic [5:0] OFF_CMD    = 6'h00;
  localparam logic [5:0] OFF_TOTAL  = 6'h04;
  localparam logic [5:0] OFF_OCTETS = 6'h0C;
  localparam logic [5:0] OFF_DISC   = 6'h14;
  localparam logic [5:0] OFF_CRC    = 6'h1C;
  localparam logic [5:0] OFF_LENERR = 6'h24;
  // The hi word of each counter sits one word above its lo word
  localparam logic [5:0] OFF_HI     = 6'h04;

  // CMD register bit positions
  localparam int CMD_SNAPSHOT = 0;
  localparam int CMD_CLEAR    = 1;

  typedef enum logic [2:0] {
    CNT_TOTAL  = 3'd0,
    CNT_OCTETS = 3'd1,
    CNT_DISC   = 3'd2,
    CNT_CRC    = 3'd3,
    CNT_LENERR = 3'd4
  } cnt_idx_e;

  // One channel's counter set; fields are sized for the widest counter,
  // bits at and above CNT_WIDTH always stay zero.
  typedef struct packed {
    logic [63:0] total;
    logic [63:0] octets;
    logic [63:0] disc;
    logic [63:0] crc;
    logic [63:0] lenerr;
  } cnt_set_t;

  // Add at width+1 bits, then either clamp to all-ones or wrap mod 2^width
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          width,
                                          input logic        saturate);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    if (sum > lim) begin
      sat_add = saturate ? lim[63:0] : (sum[63:0] & lim[63:0]);
    end else begin
      sat_add = sum[63:0];
    end
  endfunction

  // Pick one counter out of a set
  function automatic logic [63:0] cnt_field(input cnt_set_t s, input cnt_idx_e idx);
    case (idx)
      CNT_TOTAL:  cnt_field = s.total;
      CNT_OCTETS: cnt_field = s.octets;
      CNT_DISC:   cnt_field = s.disc;
      CNT_CRC:    cnt_field = s.crc;
      CNT_LENERR: cnt_field = s.lenerr;
      default:    cnt_field = '0;
    endcase
  endfunction

endpackage

// File: rtl/rx_mac_stats_ch.sv
// One channel's live and shadow counter sets with snapshot/clear.
// Live counters update on the edge after the update strobe; shadow on the command edge.
// No backpressure: one update per cycle is always absorbed.
module rx_mac_stats_ch
  import rx_mac_stats_pkg::*;
#(
  parameter int   CNT_WIDTH = 48,
  parameter int   LEN_WIDTH = 16,
  parameter logic SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 upd,
  input  logic [LEN_WIDTH-1:0] upd_len,
  input  logic                 upd_disc,
  input  logic                 upd_crc,
  input  logic                 upd_len_err,
  input  logic                 cmd_snapshot,
  input  logic                 cmd_clear,
  output cnt_set_t             shadow
);

  cnt_set_t live;
  cnt_set_t base;
  cnt_set_t live_nxt;

  // Clear first, then fold the frame in: a frame landing with CLEAR survives as 1
  always_comb begin
    base     = cmd_clear ? '0 : live;
    live_nxt = base;
    if (upd) begin
      live_nxt.total  = sat_add(base.total, 64'd1, CNT_WIDTH, SATURATE);
      live_nxt.octets = sat_add(base.octets, 64'(upd_len), CNT_WIDTH, SATURATE);
      if (upd_disc) begin
        live_nxt.disc = sat_add(base.disc, 64'd1, CNT_WIDTH, SATURATE);
      end
      if (upd_crc) begin
        live_nxt.crc = sat_add(base.crc, 64'd1, CNT_WIDTH, SATURATE);
      end
      if (upd_len_err) begin
        live_nxt.lenerr = sat_add(base.lenerr, 64'd1, CNT_WIDTH, SATURATE);
      end
    end
  end

  // Live counters; shadow captures the pre-update, pre-clear live values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live   <= '0;
      shadow <= '0;
    end else begin
      live <= live_nxt;
      if (cmd_snapshot) begin
        shadow <= live;
      end
    end
  end

endmodule

// File: rtl/rx_mac_stats_mc.sv
// Multi-channel RX MAC statistics: per-channel frame counters read over one MI32 window.
// Frame at cycle T is in the live counters at T+2; MI read data returns 1 cycle after accept.
// No backpressure: frames are always accepted, MI_ARDY follows RD|WR combinationally.
module rx_mac_stats_mc
  import rx_mac_stats_pkg::*;
#(
  parameter int   CHANNELS  = 4,
  parameter int   CNT_WIDTH = 48,
  parameter int   LEN_WIDTH = 16,
  parameter int   MIN_LEN   = 64,
  parameter int   MAX_LEN   = 1526,
  parameter logic SATURATE  = 1'b1,
  localparam int  CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_vld,
  input  logic [CH_W-1:0]      frame_ch,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic                 frame_crc_err,
  input  logic                 frame_mac_err,
  input  logic [31:0]          mi_dwr,
  input  logic [31:0]          mi_addr,
  input  logic [3:0]           mi_be,
  input  logic                 mi_rd,
  input  logic                 mi_wr,
  output logic [31:0]          mi_drd,
  output logic                 mi_ardy,
  output logic                 mi_drdy
);

  // ---------------- stage 1: metadata register and flags ----------------
  logic in_ch_ok;
  logic in_len_err;
  logic in_disc;

  assign in_ch_ok   = (32'(frame_ch) < 32'(CHANNELS));
  assign in_len_err = (64'(frame_len) < 64'(MIN_LEN)) || (64'(frame_len) > 64'(MAX_LEN));
  assign in_disc    = frame_crc_err || frame_mac_err || in_len_err;

  logic                 s1_vld;
  logic [CH_W-1:0]      s1_ch;
  logic [LEN_WIDTH-1:0] s1_len;
  logic                 s1_disc;
  logic                 s1_crc;
  logic                 s1_len_err;

  // Out-of-range channels are dropped here so stage 2 never sees them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld     <= 1'b0;
      s1_ch      <= '0;
      s1_len     <= '0;
      s1_disc    <= 1'b0;
      s1_crc     <= 1'b0;
      s1_len_err <= 1'b0;
    end else begin
      s1_vld     <= frame_vld && in_ch_ok;
      s1_ch      <= frame_ch;
      s1_len     <= frame_len;
      s1_disc    <= in_disc;
      s1_crc     <= frame_crc_err;
      s1_len_err <= in_len_err;
    end
  end

  // ---------------- MI address decode ----------------
  logic            mi_ch_ok;
  logic [CH_W-1:0] mi_ch;
  logic [5:0]      mi_off;
  logic            cmd_wr;

  assign mi_ch_ok = ({6'd0, mi_addr[31:6]} < 32'(CHANNELS));
  assign mi_ch    = mi_addr[6 +: CH_W];
  assign mi_off   = mi_addr[5:0];
  assign cmd_wr   = mi_wr && mi_be[0] && mi_ch_ok && (mi_off == OFF_CMD);
  assign mi_ardy  = mi_rd | mi_wr;

  // Only BE[0] and the two command bits carry meaning
  logic unused_mi;
  assign unused_mi = ^{mi_dwr[31:2], mi_be[3:1]};

  // ---------------- per-channel counters ----------------
  logic [CHANNELS-1:0] ch_upd;
  logic [CHANNELS-1:0] ch_snap;
  logic [CHANNELS-1:0] ch_clr;
  cnt_set_t            shadows [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign ch_upd[c]  = s1_vld && (s1_ch == CH_W'(c));
    assign ch_snap[c] = cmd_wr && (mi_ch == CH_W'(c)) && mi_dwr[CMD_SNAPSHOT];
    assign ch_clr[c]  = cmd_wr && (mi_ch == CH_W'(c)) && mi_dwr[CMD_CLEAR];

    rx_mac_stats_ch #(
      .CNT_WIDTH (CNT_WIDTH),
      .LEN_WIDTH (LEN_WIDTH),
      .SATURATE  (SATURATE)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .upd          (ch_upd[c]),
      .upd_len      (s1_len),
      .upd_disc     (s1_disc),
      .upd_crc      (s1_crc),
      .upd_len_err  (s1_len_err),
      .cmd_snapshot (ch_snap[c]),
      .cmd_clear    (ch_clr[c]),
      .shadow       (shadows[c])
    );
  end

  // ---------------- read mux ----------------
  logic        rd_hit;
  logic        rd_hi;
  cnt_idx_e    rd_idx;
  logic [63:0] rd_val;
  logic [31:0] rd_data;

  // Map the offset to a counter and half; anything else (incl. CMD) reads 0
  always_comb begin
    rd_hit  = 1'b1;
    rd_hi   = 1'b0;
    rd_idx  = CNT_TOTAL;
    rd_val  = '0;
    rd_data = '0;
    case (mi_off)
      OFF_TOTAL:           rd_idx = CNT_TOTAL;
      OFF_TOTAL + OFF_HI:  begin rd_idx = CNT_TOTAL;  rd_hi = 1'b1; end
      OFF_OCTETS:          rd_idx = CNT_OCTETS;
      OFF_OCTETS + OFF_HI: begin rd_idx = CNT_OCTETS; rd_hi = 1'b1; end
      OFF_DISC:            rd_idx = CNT_DISC;
      OFF_DISC + OFF_HI:   begin rd_idx = CNT_DISC;   rd_hi = 1'b1; end
      OFF_CRC:             rd_idx = CNT_CRC;
      OFF_CRC + OFF_HI:    begin rd_idx = CNT_CRC;    rd_hi = 1'b1; end
      OFF_LENERR:          rd_idx = CNT_LENERR;
      OFF_LENERR + OFF_HI: begin rd_idx = CNT_LENERR; rd_hi = 1'b1; end
      default:             rd_hit = 1'b0;
    endcase
    if (rd_hit && mi_ch_ok) begin
      rd_val  = cnt_field(shadows[mi_ch], rd_idx);
      rd_data = rd_hi ? rd_val[63:32] : rd_val[31:0];
    end
  end

  // Registered read return; data is forced to 0 whenever no read is returning
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mi_drdy <= 1'b0;
      mi_drd  <= '0;
    end else begin
      mi_drdy <= mi_rd;
      mi_drd  <= mi_rd ? rd_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_rx_mac_stats_mc.sv
module tb_rx_mac_stats_mc;

  localparam longint unsigned MAXV = 64'hFFFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;

  // main DUT (4 channels, 48-bit counters)
  logic        frame_vld = 0;
  logic [1:0]  frame_ch = 0;
  logic [15:0] frame_len = 0;
  logic        frame_crc_err = 0, frame_mac_err = 0;
  logic [31:0] mi_dwr = 0, mi_addr = 0;
  logic [3:0]  mi_be = 4'hF;
  logic        mi_rd = 0, mi_wr = 0;
  logic [31:0] mi_drd;
  logic        mi_ardy, mi_drdy;

  rx_mac_stats_mc u_dut (
    .clk(clk), .reset_n(reset_n), .frame_vld(frame_vld), .frame_ch(frame_ch),
    .frame_len(frame_len), .frame_crc_err(frame_crc_err), .frame_mac_err(frame_mac_err),
    .mi_dwr(mi_dwr), .mi_addr(mi_addr), .mi_be(mi_be), .mi_rd(mi_rd), .mi_wr(mi_wr),
    .mi_drd(mi_drd), .mi_ardy(mi_ardy), .mi_drdy(mi_drdy));

  // 33-bit counter DUTs, one saturating and one wrapping, sharing stimulus
  logic        s_vld = 0;
  logic [0:0]  s_ch = 0;
  logic [31:0] s_len = 0;
  logic [31:0] s_dwr = 0, s_addr = 0;
  logic        s_rd = 0, s_wr = 0;
  logic [31:0] s_drd_a, s_drd_b;
  logic        s_ardy_a, s_ardy_b, s_drdy_a, s_drdy_b;

  rx_mac_stats_mc #(.CHANNELS(1), .CNT_WIDTH(33), .LEN_WIDTH(32), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset_n(reset_n), .frame_vld(s_vld), .frame_ch(s_ch), .frame_len(s_len),
    .frame_crc_err(1'b0), .frame_mac_err(1'b0), .mi_dwr(s_dwr), .mi_addr(s_addr),
    .mi_be(4'hF), .mi_rd(s_rd), .mi_wr(s_wr), .mi_drd(s_drd_a), .mi_ardy(s_ardy_a),
    .mi_drdy(s_drdy_a));

  rx_mac_stats_mc #(.CHANNELS(1), .CNT_WIDTH(33), .LEN_WIDTH(32), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .frame_vld(s_vld), .frame_ch(s_ch), .frame_len(s_len),
    .frame_crc_err(1'b0), .frame_mac_err(1'b0), .mi_dwr(s_dwr), .mi_addr(s_addr),
    .mi_be(4'hF), .mi_rd(s_rd), .mi_wr(s_wr), .mi_drd(s_drd_b), .mi_ardy(s_ardy_b),
    .mi_drdy(s_drdy_b));

  int checks = 0;
  int failures = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the main DUT ----------------
  // Counter index k: 0 TOTAL, 1 OCTETS, 2 DISC, 3 CRC, 4 LENERR
  longint unsigned m_live [4][5];
  longint unsigned m_shad [4][5];
  logic            p_vld = 0;
  int              p_ch = 0;
  longint unsigned p_len = 0;
  logic            p_crc = 0, p_mac = 0;
  logic            exp_drdy = 0;
  logic [31:0]     exp_drd = 0;

  function automatic bit f_cmd(int c, int bitpos);
    return mi_wr && mi_be[0] && (mi_addr == 32'(c * 64)) && mi_dwr[bitpos];
  endfunction

  // Frame registered last edge lands now, on top of a cleared value if CLEAR hits
  function automatic longint unsigned f_next(int c, int k);
    longint unsigned base, inc, sum;
    bit bad;
    base = f_cmd(c, 1) ? 64'd0 : m_live[c][k];
    inc = 0;
    bad = (p_len < 64) || (p_len > 1526);
    if (p_vld && p_ch == c) begin
      case (k)
        0: inc = 1;
        1: inc = p_len;
        2: inc = (p_crc || p_mac || bad) ? 1 : 0;
        3: inc = p_crc ? 1 : 0;
        default: inc = bad ? 1 : 0;
      endcase
    end
    sum = base + inc;
    return (sum > MAXV) ? MAXV : sum;
  endfunction

  function automatic logic [31:0] f_read(logic [31:0] a);
    int c, w;
    longint unsigned v;
    if (a[31:6] >= 26'd4 || a[1:0] != 2'b00) return 32'd0;
    c = int'(a[7:6]);
    w = int'(a[5:2]);
    if (w < 1 || w > 10) return 32'd0;
    v = m_shad[c][(w - 1) / 2];
    return ((w - 1) % 2 == 1) ? v[63:32] : v[31:0];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 5; k++) begin
          m_live[c][k] <= 0;
          m_shad[c][k] <= 0;
        end
      p_vld <= 0;
      exp_drdy <= 0;
      exp_drd <= 0;
    end else begin
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 5; k++) begin
          m_live[c][k] <= f_next(c, k);
          if (f_cmd(c, 0)) m_shad[c][k] <= m_live[c][k];
        end
      p_vld <= frame_vld;
      p_ch <= int'(frame_ch);
      p_len <= 64'(frame_len);
      p_crc <= frame_crc_err;
      p_mac <= frame_mac_err;
      exp_drdy <= mi_rd;
      exp_drd <= mi_rd ? f_read(mi_addr) : 32'd0;
    end
  end

  // Compare process: MI outputs against the model every cycle
  always @(negedge clk) begin
    if (started) begin
      chk("mi_drdy", 64'(mi_drdy), 64'(exp_drdy));
      chk("mi_drd", 64'(mi_drd), 64'(exp_drd));
      chk("mi_ardy", 64'(mi_ardy), 64'(mi_rd | mi_wr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int len, input bit crc, input bit mac);
    frame_vld = 1; frame_ch = 2'(ch); frame_len = 16'(len);
    frame_crc_err = crc; frame_mac_err = mac;
    tick();
    frame_vld = 0; frame_crc_err = 0; frame_mac_err = 0;
  endtask

  task automatic mi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mi_wr = 1; mi_addr = a; mi_dwr = d; mi_be = be;
    tick();
    mi_wr = 0; mi_be = 4'hF;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    mi_rd = 1; mi_addr = a;
    tick();
    mi_rd = 0;
    @(negedge clk);
    d = mi_drd;
    chk({name, "_drdy"}, 64'(mi_drdy), 64'd1);
    chk(name, 64'(d), 64'(exp));
    tick();
  endtask

  task automatic s_send(input bit ch, input logic [31:0] len);
    s_vld = 1; s_ch = ch; s_len = len;
    tick();
    s_vld = 0;
  endtask

  task automatic s_snap();
    s_wr = 1; s_addr = 32'h0; s_dwr = 32'h1;
    tick();
    s_wr = 0;
  endtask

  task automatic s_rd_chk(input string name, input logic [31:0] a,
                          input logic [31:0] exp_sat, input logic [31:0] exp_wrap);
    s_rd = 1; s_addr = a;
    tick();
    s_rd = 0;
    @(negedge clk);
    chk({name, "_sat"}, 64'(s_drd_a), 64'(exp_sat));
    chk({name, "_wrap"}, 64'(s_drd_b), 64'(exp_wrap));
    chk({name, "_drdy"}, 64'(s_drdy_a & s_drdy_b), 64'd1);
    tick();
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    started = 1;

    // reset state
    rd_chk("rst_total_ch0", 32'h04, 32'd0);
    rd_chk("rst_octets_ch3", 32'hCC, 32'd0);

    // ch2: three clean 100-byte frames
    for (int i = 0; i < 3; i++) send(2, 100, 0, 0);
    tick(); tick();
    mi_write(32'h80, 32'h1, 4'hF);
    rd_chk("ch2_total", 32'h84, 32'd3);
    rd_chk("ch2_total_hi", 32'h88, 32'd0);
    rd_chk("ch2_octets", 32'h8C, 32'd300);
    rd_chk("ch2_disc", 32'h94, 32'd0);
    rd_chk("ch0_total_untouched", 32'h04, 32'd0);
    rd_chk("ch1_total_untouched", 32'h44, 32'd0);
    rd_chk("ch3_total_untouched", 32'hC4, 32'd0);

    // ch0: length boundaries
    send(0, 63, 0, 0); send(0, 64, 0, 0); send(0, 1526, 0, 0); send(0, 1527, 0, 0);
    tick(); tick();
    mi_write(32'h00, 32'h1, 4'hF);
    rd_chk("ch0_total", 32'h04, 32'd4);
    rd_chk("ch0_disc", 32'h14, 32'd2);
    rd_chk("ch0_lenerr", 32'h24, 32'd2);
    rd_chk("ch0_crc", 32'h1C, 32'd0);
    rd_chk("ch0_octets", 32'h0C, 32'd3180);

    // ch1: one frame hitting every error counter
    send(1, 60, 1, 1);
    tick(); tick();
    mi_write(32'h40, 32'h1, 4'hF);
    rd_chk("ch1_total", 32'h44, 32'd1);
    rd_chk("ch1_disc", 32'h54, 32'd1);
    rd_chk("ch1_crc", 32'h5C, 32'd1);
    rd_chk("ch1_lenerr", 32'h64, 32'd1);
    // CLEAR alone, then snapshot shows empty counters
    mi_write(32'h40, 32'h2, 4'hF);
    mi_write(32'h40, 32'h1, 4'hF);
    rd_chk("ch1_after_clear", 32'h44, 32'd0);

    // write without BE[0] is ignored
    send(0, 100, 0, 0);
    tick(); tick();
    mi_write(32'h00, 32'h1, 4'hE);
    rd_chk("ch0_no_be0", 32'h04, 32'd4);
    mi_write(32'h00, 32'h1, 4'hF);
    rd_chk("ch0_with_be0", 32'h04, 32'd5);
    rd_chk("ch0_octets2", 32'h0C, 32'd3280);

    // ch3: atomic read-and-clear while the 4th frame is in stage 2
    for (int i = 0; i < 5; i++) begin
      frame_vld = (i < 4); frame_ch = 2'd3; frame_len = 16'd100;
      mi_wr = (i == 4); mi_addr = 32'hC0; mi_dwr = 32'h3; mi_be = 4'hF;
      tick();
    end
    frame_vld = 0; mi_wr = 0;
    rd_chk("ch3_rc_total", 32'hC4, 32'd3);
    rd_chk("ch3_rc_octets", 32'hCC, 32'd300);
    mi_write(32'hC0, 32'h1, 4'hF);
    rd_chk("ch3_post_total", 32'hC4, 32'd1);
    rd_chk("ch3_post_octets", 32'hCC, 32'd100);
    mi_write(32'h80, 32'h1, 4'hF);
    rd_chk("ch2_still_3", 32'h84, 32'd3);

    // unmapped and out-of-range reads
    rd_chk("unmapped_2c", 32'h2C, 32'd0);
    rd_chk("cmd_reads_0", 32'h00, 32'd0);
    rd_chk("ch4_reads_0", 32'h104, 32'd0);

    // 33-bit counters: OCTETS reaches 2^33-1, then one more byte
    s_send(0, 32'hFFFF_FFFF); s_send(0, 32'hFFFF_FFFF); s_send(0, 32'd1);
    tick(); tick();
    s_snap();
    s_rd_chk("oct_full_lo", 32'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    s_rd_chk("oct_full_hi", 32'h10, 32'h1, 32'h1);
    s_send(0, 32'd1);
    tick(); tick();
    s_snap();
    s_rd_chk("oct_over_lo", 32'h0C, 32'hFFFF_FFFF, 32'h0);
    s_rd_chk("oct_over_hi", 32'h10, 32'h1, 32'h0);
    s_rd_chk("s_total", 32'h04, 32'd4, 32'd4);
    // frames on channel == CHANNELS change nothing
    s_send(1, 32'd100); s_send(1, 32'd100);
    tick(); tick();
    s_snap();
    s_rd_chk("s_total_oob", 32'h04, 32'd4, 32'd4);
    s_rd_chk("s_ch1_reads_0", 32'h44, 32'd0, 32'd0);

    // reset asserted mid-stream with a read pending
    frame_vld = 1; frame_ch = 2'd3; frame_len = 16'd100;
    tick();
    reset_n = 0; mi_rd = 1; mi_addr = 32'h84;
    #2;
    chk("drdy_in_reset_a", 64'(mi_drdy), 64'd0);
    tick(); tick();
    @(negedge clk);
    chk("drdy_in_reset_b", 64'(mi_drdy), 64'd0);
    @(posedge clk); #1;
    frame_vld = 0; mi_rd = 0; reset_n = 1;
    tick();
    rd_chk("rst_ch2_shadow", 32'h84, 32'd0);
    mi_write(32'hC0, 32'h1, 4'hF);
    mi_write(32'h80, 32'h1, 4'hF);
    rd_chk("rst_ch3_live", 32'hC4, 32'd0);
    rd_chk("rst_ch2_live", 32'h84, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
